// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit master: FSM encoding, SPI mode codes
// and parameter legality helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic bit clk_div_legal(input int unsigned clk_div);
    return clk_div >= 2;
  endfunction

  function automatic bit data_width_legal(input int unsigned data_width);
    return data_width >= 2;
  endfunction

endpackage

// File: rtl/spi_clk_en.sv
// Half-period strobe generator: counts CLK_DIV system clocks, restartable so a
// new phase always begins with a full half-period.
module spi_clk_en
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic half_tick,
  output logic pre_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || restart || half_tick) count <= '0;
    else                                count <= count + 1'b1;
  end

  assign half_tick = (count == CW'(CLK_DIV - 1));
  // One cycle ahead of half_tick, lets the top register its ready window.
  assign pre_tick  = (count == CW'(CLK_DIV - 2));

endmodule

// File: rtl/spi_master_tx.sv
// Single-clock SPI transmit master for the OLED link: valid/ready word input,
// configurable width, divider, CPOL/CPHA and bit order, back-to-back streaming.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 5,
  parameter bit          CPOL       = 1'b1,
  parameter bit          CPHA       = 1'b1,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_dc,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  spi_clock,
  output logic                  spi_data,
  output logic                  spi_cs_n,
  output logic                  spi_dc,
  output logic                  busy,
  output logic                  done_send
);

  if (!clk_div_legal(CLK_DIV) || !data_width_legal(DATA_WIDTH)) begin : g_param_check
    $error("spi_master_tx: CLK_DIV and DATA_WIDTH must both be >= 2");
  end

  localparam int unsigned     BW     = $clog2(2 * DATA_WIDTH);
  localparam logic [BW-1:0]   K_LAST = BW'(2 * DATA_WIDTH - 1);

  spi_state_t            state;
  logic [DATA_WIDTH-1:0] sreg;
  logic                  last_r;
  logic [BW-1:0]         k;
  logic                  half_tick;
  logic                  pre_tick;
  logic                  accept;

  assign accept = tx_valid && tx_ready;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  spi_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en (
    .clock     (clock),
    .reset     (reset),
    .restart   (state == IDLE),
    .half_tick (half_tick),
    .pre_tick  (pre_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      spi_cs_n  <= 1'b1;
      spi_clock <= CPOL;
      spi_data  <= 1'b0;
      spi_dc    <= 1'b0;
      done_send <= 1'b0;
      busy      <= 1'b0;
      tx_ready  <= 1'b0;
      sreg      <= '0;
      last_r    <= 1'b0;
      k         <= '0;
    end else begin
      done_send <= 1'b0;
      case (state)
        IDLE: begin
          spi_clock <= CPOL;
          spi_cs_n  <= 1'b1;
          spi_data  <= 1'b0;
          if (accept) begin
            sreg     <= shift_out(tx_data);
            spi_data <= first_bit(tx_data);
            spi_dc   <= tx_dc;
            last_r   <= tx_last;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (half_tick) begin
            state     <= SHIFT;
            k         <= '0;
            spi_clock <= CPOL ^ CPHA;
          end
        end

        SHIFT: begin
          if (pre_tick && k == K_LAST && !last_r) tx_ready <= 1'b1;
          if (half_tick) begin
            spi_clock <= ~spi_clock;
            if (k == K_LAST) begin
              done_send <= 1'b1;
              tx_ready  <= 1'b0;
              k         <= '0;
              // Streamed word: stay in SHIFT, cs_n stays low, first bit launched now.
              if (accept) begin
                sreg     <= shift_out(tx_data);
                spi_data <= first_bit(tx_data);
                spi_dc   <= tx_dc;
                last_r   <= tx_last;
              end else begin
                state     <= HOLD;
                spi_clock <= CPOL;
              end
            end else begin
              k <= k + 1'b1;
              if (k[0]) begin
                spi_data <= first_bit(sreg);
                sreg     <= shift_out(sreg);
              end
            end
          end
        end

        HOLD: begin
          if (half_tick) begin
            state    <= IDLE;
            spi_cs_n <= 1'b1;
            spi_data <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
